prbs_lfsr_gen_chk: RTL and testbench



---
 rtl/prbs_pkg.sv | 50 +++++
 rtl/prbs_lfsr_gen_chk_step.sv | 33 +++
 rtl/prbs_lfsr_gen_chk.sv | 191 +++++++++++++++++++
 tb/tb_prbs_lfsr_gen_chk.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared LFSR helpers and checker state encoding for the PRBS generator/checker.
package prbs_pkg;

    // Widest LFSR the helper functions handle; narrower registers are zero-extended.
    localparam int unsigned MaxWidth = 64;

    localparam logic [30:0] DefTaps = 31'h4800_0000;
    localparam logic [30:0] DefSeed = 31'h0000_0001;

    // Checker states.
    typedef logic [0:0] chk_state_t;
    localparam chk_state_t StSearch = 1'b0;
    localparam chk_state_t StLocked = 1'b1;

    // Feedback bit: XOR of the tapped state bits.
    function automatic logic lfsr_fb(input logic [MaxWidth-1:0] s,
                                     input logic [MaxWidth-1:0] taps);
        return ^(s & taps);
    endfunction

    // Shift one bit into the LSB of a width-bit register.
    function automatic logic [MaxWidth-1:0] lfsr_shift(input logic [MaxWidth-1:0] s,
                                                       input int unsigned         width,
                                                       input logic                in_bit);
        logic [MaxWidth-1:0] one;
        logic [MaxWidth-1:0] mask;
        one  = MaxWidth'(1);
        // width == MaxWidth wraps the shift to zero, and 0 - 1 is the all-ones mask.
        mask = (one << width) - one;
        return ((s << 1) | MaxWidth'(in_bit)) & mask;
    endfunction

    // One autonomous Fibonacci step.
    function automatic logic [MaxWidth-1:0] lfsr_step(input logic [MaxWidth-1:0] s,
                                                      input logic [MaxWidth-1:0] taps,
                                                      input int unsigned         width);
        return lfsr_shift(s, width, lfsr_fb(s, taps));
    endfunction

    // Number of set bits.
    function automatic int unsigned popcount(input logic [MaxWidth-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs_lfsr_gen_chk_step.sv
// Combinational STEPS-step LFSR unroller. With use_ext low it runs free (feedback is
// shifted in); with use_ext high the external bits are shifted in instead.
module prbs_step
    import prbs_pkg::*;
#(
    parameter int unsigned       WIDTH = 31,
    parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(DefTaps),
    parameter int unsigned       STEPS = 1
) (
    input  logic [WIDTH-1:0] state_in,
    input  logic             use_ext,
    input  logic [STEPS-1:0] ext_bits,
    output logic [WIDTH-1:0] state_out,
    output logic [STEPS-1:0] out_bits,   // register MSB before each step, bit 0 first
    output logic [STEPS-1:0] pred_bits   // feedback value before each step
);

    logic [MaxWidth-1:0] walk;

    // Walk the register through STEPS single steps.
    always_comb begin
        walk      = MaxWidth'(state_in);
        out_bits  = '0;
        pred_bits = '0;
        for (int unsigned k = 0; k < STEPS; k++) begin
            out_bits[k]  = walk[WIDTH-1];
            pred_bits[k] = lfsr_fb(walk, MaxWidth'(TAPS));
            walk         = lfsr_shift(walk, WIDTH, use_ext ? ext_bits[k] : pred_bits[k]);
        end
        state_out = WIDTH'(walk);
    end

endmodule

// File: rtl/prbs_lfsr_gen_chk.sv
// PRBS pattern generator plus self-synchronising pattern checker sharing one LFSR
// definition. The generator emits STEPS bits per enabled clock; the checker locks onto
// an incoming stream, then flywheels on its own predictions and counts bit errors.
module prbs_lfsr_gen_chk
    import prbs_pkg::*;
#(
    parameter int unsigned      WIDTH      = 31,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DefTaps),
    parameter logic [WIDTH-1:0] SEED       = WIDTH'(DefSeed),
    parameter int unsigned      STEPS      = 1,
    parameter int unsigned      SYNC_BEATS = 4,
    parameter int unsigned      LOSS_BEATS = 4,
    parameter int unsigned      CNTW       = 16
) (
    input  logic             clk,
    input  logic             rst_n,        // synchronous, active high
    // Generator
    input  logic             gen_en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_val,
    output logic [WIDTH-1:0] gen_state,
    output logic [STEPS-1:0] gen_bits,
    output logic             gen_lockup,
    // Checker
    input  logic             chk_valid,
    input  logic [STEPS-1:0] chk_bits,
    output logic             chk_locked,
    output logic [CNTW-1:0]  chk_err_cnt,
    input  logic             chk_err_clr
);

    localparam int unsigned FillW   = $clog2(WIDTH + 1);
    localparam int unsigned GoodW   = $clog2(SYNC_BEATS + 1);
    localparam int unsigned BadW    = $clog2(LOSS_BEATS + 1);
    localparam int unsigned CntSumW = CNTW + 1;

    // ---------------------------------------------------------------- generator

    logic [WIDTH-1:0] gen_q, gen_d, gen_stepped;
    logic             lockup_q, lockup_d;

    prbs_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .STEPS (STEPS)
    ) u_gen_step (
        .state_in  (gen_q),
        .use_ext   (1'b0),
        .ext_bits  ({STEPS{1'b0}}),
        .state_out (gen_stepped),
        .out_bits  (gen_bits),
        .pred_bits ()
    );

    // Generator next state: seed load, then zero-state recovery, then stepping.
    always_comb begin
        gen_d    = gen_q;
        lockup_d = 1'b0;
        if (seed_load) begin
            // An all-zero seed would lock the LFSR, so fall back to SEED.
            gen_d = (seed_val == '0) ? SEED : seed_val;
        end else if (gen_q == '0) begin
            gen_d    = SEED;
            lockup_d = 1'b1;
        end else if (gen_en) begin
            gen_d = gen_stepped;
        end
    end

    // Generator registers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            gen_q    <= SEED;
            lockup_q <= 1'b0;
        end else begin
            gen_q    <= gen_d;
            lockup_q <= lockup_d;
        end
    end

    assign gen_state  = gen_q;
    assign gen_lockup = lockup_q;

    // ---------------------------------------------------------------- checker

    chk_state_t       state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d, r_stepped;
    logic [FillW-1:0] fill_q, fill_d, fill_next;
    logic [GoodW-1:0] good_q, good_d;
    logic [BadW-1:0]  bad_q, bad_d;
    logic [CNTW-1:0]  cnt_q, cnt_d, cnt_next;
    logic [STEPS-1:0] pred_bits, err_bits;
    logic [31:0]      fill_sum, err_pop;
    logic [CntSumW-1:0] cnt_sum;
    logic             searching;

    assign searching = (state_q == StSearch);

    // While searching the register tracks the received stream; once locked it
    // flywheels on its own predictions so line errors do not corrupt it.
    prbs_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .STEPS (STEPS)
    ) u_chk_step (
        .state_in  (r_q),
        .use_ext   (searching),
        .ext_bits  (chk_bits),
        .state_out (r_stepped),
        .out_bits  (),
        .pred_bits (pred_bits)
    );

    assign err_bits = pred_bits ^ chk_bits;
    assign err_pop  = 32'(popcount(MaxWidth'(err_bits)));

    // Saturating fill and error-count arithmetic.
    assign fill_sum  = 32'(fill_q) + 32'(STEPS);
    assign fill_next = (fill_sum >= 32'(WIDTH)) ? FillW'(WIDTH) : FillW'(fill_sum);
    assign cnt_sum   = {1'b0, cnt_q} + CntSumW'(err_pop);
    assign cnt_next  = cnt_sum[CNTW] ? {CNTW{1'b1}} : cnt_sum[CNTW-1:0];

    // Checker next state: one beat per valid cycle, error clear wins over counting.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        fill_d  = fill_q;
        good_d  = good_q;
        bad_d   = bad_q;
        cnt_d   = cnt_q;
        if (chk_valid) begin
            r_d = r_stepped;
            if (searching) begin
                fill_d = fill_next;
                // Only judge beats whose starting register was fully filled.
                if (fill_q == FillW'(WIDTH)) begin
                    if (err_bits == '0 && r_q != '0) begin
                        good_d = good_q + GoodW'(1);
                    end else begin
                        good_d = '0;
                    end
                end
                if (good_d == GoodW'(SYNC_BEATS)) begin
                    state_d = StLocked;
                    fill_d  = '0;
                    good_d  = '0;
                    bad_d   = '0;
                end
            end else begin
                cnt_d = cnt_next;
                if (err_bits != '0) begin
                    bad_d = bad_q + BadW'(1);
                end else begin
                    bad_d = '0;
                end
                if (bad_d == BadW'(LOSS_BEATS)) begin
                    state_d = StSearch;
                    fill_d  = '0;
                    good_d  = '0;
                    bad_d   = '0;
                end
            end
        end
        if (chk_err_clr) begin
            cnt_d = '0;
        end
    end

    // Checker registers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= StSearch;
            r_q     <= '0;
            fill_q  <= '0;
            good_q  <= '0;
            bad_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            fill_q  <= fill_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
        end
    end

    assign chk_locked  = (state_q == StLocked);
    assign chk_err_cnt = cnt_q;

endmodule

// File: tb/tb_prbs_lfsr_gen_chk.sv
// Bench for prbs_lfsr_gen_chk: a default 31-bit single-step instance (A) and a 7-bit,
// 8-steps-per-clock instance (B), each with its generator looped into its checker.
module tb_prbs_lfsr_gen_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Instance A: defaults.
    logic        rst_a = 1'b1, gen_en_a = 1'b0, seed_load_a = 1'b0;
    logic [30:0] seed_val_a = '0, gen_state_a;
    logic [0:0]  gen_bits_a, chk_bits_a;
    logic        gen_lockup_a, chk_valid_a = 1'b0, chk_locked_a, clr_a = 1'b0;
    logic [15:0] cnt_a;
    logic        loop_a = 1'b0;
    logic [0:0]  flip_a = '0, force_a = '0;

    assign chk_bits_a = loop_a ? (gen_bits_a ^ flip_a) : force_a;

    prbs_lfsr_gen_chk dut_a (
        .clk         (clk),
        .rst_n       (rst_a),
        .gen_en      (gen_en_a),
        .seed_load   (seed_load_a),
        .seed_val    (seed_val_a),
        .gen_state   (gen_state_a),
        .gen_bits    (gen_bits_a),
        .gen_lockup  (gen_lockup_a),
        .chk_valid   (chk_valid_a),
        .chk_bits    (chk_bits_a),
        .chk_locked  (chk_locked_a),
        .chk_err_cnt (cnt_a),
        .chk_err_clr (clr_a)
    );

    // Instance B: WIDTH 7, 8 steps per clock.
    logic       rst_b = 1'b1, gen_en_b = 1'b0, seed_load_b = 1'b0;
    logic [6:0] seed_val_b = '0, gen_state_b;
    logic [7:0] gen_bits_b, chk_bits_b;
    logic       gen_lockup_b, chk_valid_b = 1'b0, chk_locked_b, clr_b = 1'b0;
    logic [15:0] cnt_b;
    logic [7:0] flip_b = '0;

    assign chk_bits_b = gen_bits_b ^ flip_b;

    prbs_lfsr_gen_chk #(
        .WIDTH (7),
        .TAPS  (7'h60),
        .SEED  (7'h01),
        .STEPS (8)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_b),
        .gen_en      (gen_en_b),
        .seed_load   (seed_load_b),
        .seed_val    (seed_val_b),
        .gen_state   (gen_state_b),
        .gen_bits    (gen_bits_b),
        .gen_lockup  (gen_lockup_b),
        .chk_valid   (chk_valid_b),
        .chk_bits    (chk_bits_b),
        .chk_locked  (chk_locked_b),
        .chk_err_cnt (cnt_b),
        .chk_err_clr (clr_b)
    );

    // Scoreboards of expected generator states.
    logic [30:0] sb_a[$];
    logic [6:0]  sb_b[$];

    // Reference LFSR models, written directly from the polynomial taps.
    function automatic logic [30:0] model_a(input logic [30:0] s);
        return {s[29:0], s[30] ^ s[27]};
    endfunction

    function automatic logic [6:0] model_b(input logic [6:0] s);
        logic [6:0] t;
        t = s;
        for (int k = 0; k < 8; k++) t = {t[5:0], t[6] ^ t[5]};
        return t;
    endfunction

    function automatic logic [7:0] emit_b(input logic [6:0] s);
        logic [6:0] t;
        logic [7:0] b;
        t = s;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            b[k] = t[6];
            t    = {t[5:0], t[6] ^ t[5]};
        end
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1; gen_en_a = 1'b0; chk_valid_a = 1'b0; loop_a = 1'b0;
        flip_a = '0; clr_a = 1'b0; seed_load_a = 1'b0;
        tick();
        rst_a = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_total++;
        if (gen_state_a !== 31'h0000_0001) $display("FAIL rst_gen_state got %h want 00000001", gen_state_a);
        else n_pass++;
        n_total++;
        if (gen_bits_a !== 1'b0) $display("FAIL rst_gen_bits got %b want 0", gen_bits_a);
        else n_pass++;
        n_total++;
        if ({gen_lockup_a, chk_locked_a, cnt_a} !== 18'd0)
            $display("FAIL rst_chk_a got lockup=%b locked=%b cnt=%h want 0/0/0",
                     gen_lockup_a, chk_locked_a, cnt_a);
        else n_pass++;
        n_total++;
        if (gen_state_b !== 7'h01 || chk_locked_b !== 1'b0)
            $display("FAIL rst_b got state=%h locked=%b want 01/0", gen_state_b, chk_locked_b);
        else n_pass++;
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic test_gen_run();
        logic [30:0] m, e;
        m = 31'h1;
        gen_en_a = 1'b1;
        for (int i = 0; i < 30; i++) begin
            m = model_a(m);
            sb_a.push_back(m);
            tick();
            e = sb_a.pop_front();
            n_total++;
            if (gen_state_a !== e || gen_bits_a[0] !== e[30])
                $display("FAIL gen_run[%0d] got %h/%b want %h/%b", i, gen_state_a,
                         gen_bits_a, e, e[30]);
            else n_pass++;
        end
        gen_en_a = 1'b0;
        n_total++;
        if (gen_state_a !== 31'h4000_0004 || gen_bits_a !== 1'b1)
            $display("FAIL gen_30 got %h/%b want 40000004/1", gen_state_a, gen_bits_a);
        else n_pass++;
    endtask

    task automatic test_seed();
        logic [30:0] e;
        seed_load_a = 1'b1; seed_val_a = '0; gen_en_a = 1'b1;
        tick();
        n_total++;
        if (gen_state_a !== 31'h1 || gen_lockup_a !== 1'b0)
            $display("FAIL seed_zero got %h lockup=%b want 00000001/0", gen_state_a, gen_lockup_a);
        else n_pass++;
        seed_val_a = 31'h1234_5678;
        tick();
        n_total++;
        if (gen_state_a !== 31'h1234_5678)
            $display("FAIL seed_load got %h want 12345678", gen_state_a);
        else n_pass++;
        seed_load_a = 1'b0;
        sb_a.push_back(model_a(31'h1234_5678));
        tick();
        e = sb_a.pop_front();
        n_total++;
        if (gen_state_a !== e) $display("FAIL seed_step got %h want %h", gen_state_a, e);
        else n_pass++;
        gen_en_a = 1'b0;
        tick();
        n_total++;
        if (gen_state_a !== e || gen_lockup_a !== 1'b0)
            $display("FAIL hold got %h lockup=%b want %h/0", gen_state_a, gen_lockup_a, e);
        else n_pass++;
    endtask

    // Looped single-step stream: 31 fill beats + 4 good beats.
    task automatic test_lock();
        logic early;
        early = 1'b0;
        reset_a();
        loop_a = 1'b1; gen_en_a = 1'b1; chk_valid_a = 1'b1;
        for (int b = 1; b <= 35; b++) begin
            tick();
            if (b <= 34 && chk_locked_a) early = 1'b1;
        end
        n_total++;
        if (early) $display("FAIL lock_early got locked before beat 35 want 0");
        else n_pass++;
        n_total++;
        if (chk_locked_a !== 1'b1) $display("FAIL lock_35 got %b want 1", chk_locked_a);
        else n_pass++;
        n_total++;
        if (cnt_a !== 16'd0) $display("FAIL lock_cnt got %0d want 0", cnt_a);
        else n_pass++;
    endtask

    task automatic test_errors();
        flip_a = 1'b1;
        tick();
        flip_a = 1'b0;
        n_total++;
        if (cnt_a !== 16'd1 || chk_locked_a !== 1'b1)
            $display("FAIL single_err got cnt=%0d locked=%b want 1/1", cnt_a, chk_locked_a);
        else n_pass++;
        tick();
        flip_a = 1'b1;
        repeat (3) tick();
        n_total++;
        if (chk_locked_a !== 1'b1) $display("FAIL loss_3 got %b want 1", chk_locked_a);
        else n_pass++;
        tick();
        n_total++;
        if (chk_locked_a !== 1'b0 || cnt_a !== 16'd5)
            $display("FAIL loss_4 got locked=%b cnt=%0d want 0/5", chk_locked_a, cnt_a);
        else n_pass++;
        flip_a = 1'b0; gen_en_a = 1'b0; chk_valid_a = 1'b0; clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        n_total++;
        if (cnt_a !== 16'd0) $display("FAIL err_clr got %0d want 0", cnt_a);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        reset_a();
        loop_a = 1'b1; gen_en_a = 1'b1; chk_valid_a = 1'b1;
        repeat (35) tick();
        n_total++;
        if (chk_locked_a !== 1'b1) $display("FAIL relock got %b want 1", chk_locked_a);
        else n_pass++;
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0; gen_en_a = 1'b0; chk_valid_a = 1'b0;
        n_total++;
        if (chk_locked_a !== 1'b0 || gen_state_a !== 31'h1)
            $display("FAIL mid_reset got locked=%b state=%h want 0/00000001",
                     chk_locked_a, gen_state_a);
        else n_pass++;
    endtask

    task automatic test_zero_stream();
        logic seen;
        seen = 1'b0;
        reset_a();
        force_a = '0; chk_valid_a = 1'b1;
        for (int b = 0; b < 100; b++) begin
            tick();
            if (chk_locked_a) seen = 1'b1;
        end
        chk_valid_a = 1'b0;
        n_total++;
        if (seen || cnt_a !== 16'd0)
            $display("FAIL zero_stream got locked_seen=%b cnt=%0d want 0/0", seen, cnt_a);
        else n_pass++;
    endtask

    // Wide instance: lock after 1 fill + 4 good beats, period 127 bit-steps.
    task automatic test_wide();
        logic [6:0] m, e;
        m = 7'h01;
        gen_en_b = 1'b1; chk_valid_b = 1'b1;
        for (int b = 1; b <= 127; b++) begin
            n_total++;
            if (gen_bits_b !== emit_b(m))
                $display("FAIL wide_bits[%0d] got %h want %h", b, gen_bits_b, emit_b(m));
            else n_pass++;
            m = model_b(m);
            sb_b.push_back(m);
            tick();
            e = sb_b.pop_front();
            n_total++;
            if (gen_state_b !== e) $display("FAIL wide_state[%0d] got %h want %h", b, gen_state_b, e);
            else n_pass++;
            if (b == 4) begin
                n_total++;
                if (chk_locked_b !== 1'b0) $display("FAIL wide_lock_4 got %b want 0", chk_locked_b);
                else n_pass++;
            end
            if (b == 5) begin
                n_total++;
                if (chk_locked_b !== 1'b1) $display("FAIL wide_lock_5 got %b want 1", chk_locked_b);
                else n_pass++;
            end
        end
        n_total++;
        if (gen_state_b !== 7'h01) $display("FAIL wide_period got %h want 01", gen_state_b);
        else n_pass++;
    endtask

    // Three all-errored beats then a clean one keeps lock while adding 24 errors.
    task automatic test_saturate();
        for (int g = 0; g < 2735; g++) begin
            flip_b = 8'hFF;
            repeat (3) tick();
            flip_b = 8'h00;
            tick();
            if (g == 0) begin
                n_total++;
                if (cnt_b !== 16'd24 || chk_locked_b !== 1'b1)
                    $display("FAIL sat_first got cnt=%0d locked=%b want 24/1", cnt_b, chk_locked_b);
                else n_pass++;
            end
        end
        n_total++;
        if (cnt_b !== 16'hFFFF || chk_locked_b !== 1'b1)
            $display("FAIL sat_max got cnt=%h locked=%b want ffff/1", cnt_b, chk_locked_b);
        else n_pass++;
        flip_b = 8'hFF;
        tick();
        n_total++;
        if (cnt_b !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", cnt_b);
        else n_pass++;
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0; flip_b = 8'h00;
        n_total++;
        if (cnt_b !== 16'd0) $display("FAIL clr_over_inc got %0d want 0", cnt_b);
        else n_pass++;
        gen_en_b = 1'b0; chk_valid_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_gen_run();
        test_seed();
        test_lock();
        test_errors();
        test_mid_reset();
        test_zero_stream();
        test_wide();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout got no finish want finish within bound");
        $fatal(1, "timeout");
    end

endmodule
